// File: rtl/acc_cpu_pkg.sv
`default_nettype none
// ============================================================================
//  acc_cpu_pkg : opcodes and FSM state encoding for the accumulator CPU core
//  Rev 1.0
// ============================================================================
package acc_cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADDI = 4'h2;
    localparam logic [3:0] OP_SUBI = 4'h3;
    localparam logic [3:0] OP_ANDI = 4'h4;
    localparam logic [3:0] OP_ORI  = 4'h5;
    localparam logic [3:0] OP_XORI = 4'h6;
    localparam logic [3:0] OP_ST   = 4'h7;
    localparam logic [3:0] OP_LD   = 4'h8;
    localparam logic [3:0] OP_ADD  = 4'h9;
    localparam logic [3:0] OP_SUB  = 4'hA;
    localparam logic [3:0] OP_SHL  = 4'hB;
    localparam logic [3:0] OP_SHR  = 4'hC;
    localparam logic [3:0] OP_OUT  = 4'hD;
    localparam logic [3:0] OP_HLT  = 4'hE;
    localparam logic [3:0] OP_RSV  = 4'hF;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/acc_cpu_alu.sv
`default_nettype none
// ============================================================================
//  acc_cpu_alu : combinational ALU producing the next accumulator and carry
//  Rev 1.0
// ============================================================================
module acc_cpu_alu #(
    parameter int DW = 8
) (
    input  logic [3:0]    opcode,
    input  logic [DW-1:0] acc,
    input  logic [DW-1:0] operand,
    output logic [DW-1:0] result,
    output logic          carry,
    output logic          writes_acc
);
    import acc_cpu_pkg::*;

    logic [DW:0] w_sum;
    logic [DW:0] w_diff;

    // The extra top bit of the difference is exactly the unsigned borrow.
    assign w_sum  = {1'b0, acc} + {1'b0, operand};
    assign w_diff = {1'b0, acc} - {1'b0, operand};

    always_comb begin
        result     = acc;
        carry      = 1'b0;
        writes_acc = 1'b1;
        case (opcode)
            OP_LDI, OP_LD:   result = operand;
            OP_ADDI, OP_ADD: {carry, result} = w_sum;
            OP_SUBI, OP_SUB: {carry, result} = w_diff;
            OP_ANDI:         result = acc & operand;
            OP_ORI:          result = acc | operand;
            OP_XORI:         result = acc ^ operand;
            OP_SHL: begin
                result = {acc[DW-2:0], 1'b0};
                carry  = acc[DW-1];
            end
            OP_SHR: begin
                result = {1'b0, acc[DW-1:1]};
                carry  = acc[0];
            end
            default:         writes_acc = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/acc_cpu_core.sv
`default_nettype none
// ============================================================================
//  acc_cpu_core : two-state fetch/execute accumulator CPU with register file
//  Rev 1.0
// ============================================================================
module acc_cpu_core #(
    parameter  int DW = 8,
    parameter  int RA = 2,
    localparam int IW = DW + 4
) (
    input  logic          clk,
    input  logic          Rst,
    input  logic [IW-1:0] instr_in,
    input  logic          instr_valid,
    output logic          instr_ready,
    output logic [DW-1:0] data_out,
    output logic          out_valid,
    output logic          flag_c,
    output logic          flag_z,
    output logic          halted
);
    import acc_cpu_pkg::*;

    localparam int NREG = 1 << RA;

    state_t        r_state;
    state_t        w_next;
    logic [IW-1:0] r_instr;
    logic [DW-1:0] r_acc;
    logic [DW-1:0] r_regs [NREG];

    logic [3:0]    w_opcode;
    logic [DW-1:0] w_imm;
    logic [RA-1:0] w_ridx;
    logic [DW-1:0] w_operand;
    logic [DW-1:0] w_result;
    logic          w_carry;
    logic          w_writes_acc;

    assign w_opcode  = r_instr[IW-1:DW];
    assign w_imm     = r_instr[DW-1:0];
    assign w_ridx    = w_imm[RA-1:0];
    assign w_operand = (w_opcode == OP_LD || w_opcode == OP_ADD || w_opcode == OP_SUB)
                       ? r_regs[w_ridx] : w_imm;

    acc_cpu_alu #(.DW(DW)) u_alu (
        .opcode     (w_opcode),
        .acc        (r_acc),
        .operand    (w_operand),
        .result     (w_result),
        .carry      (w_carry),
        .writes_acc (w_writes_acc)
    );

    always_comb begin
        w_next      = r_state;
        instr_ready = 1'b0;
        halted      = 1'b0;
        case (r_state)
            FETCH: begin
                instr_ready = 1'b1;
                if (instr_valid) w_next = EXEC;
            end
            EXEC:    w_next = (w_opcode == OP_HLT) ? HALT : FETCH;
            HALT:    halted = 1'b1;
            default: w_next = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            r_state   <= FETCH;
            r_instr   <= '0;
            r_acc     <= '0;
            flag_c    <= 1'b0;
            flag_z    <= 1'b1;
            data_out  <= '0;
            out_valid <= 1'b0;
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else begin
            r_state   <= w_next;
            out_valid <= 1'b0;
            if (r_state == FETCH && instr_valid) r_instr <= instr_in;
            // All architectural state changes happen only on the EXEC edge.
            if (r_state == EXEC) begin
                if (w_writes_acc) begin
                    r_acc  <= w_result;
                    flag_c <= w_carry;
                    flag_z <= (w_result == '0);
                end
                if (w_opcode == OP_ST) r_regs[w_ridx] <= r_acc;
                if (w_opcode == OP_OUT) begin
                    data_out  <= r_acc;
                    out_valid <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/acc_cpu_core.md
# acc_cpu_core

Parametrised accumulator CPU core, the next generation of the fixed 12-bit-instruction / 8-bit-output core. It accepts a stream of instructions over a valid/ready handshake and executes each in a two-state fetch/execute FSM against an accumulator, a small register file and carry/zero flags. It drives a registered output port with a strobe and supports halting. It sits between the instruction source (bench or program ROM sequencer) and the output consumer.

## Interface
- DW, 8, data/accumulator width (≥4)
- RA, 2, register-file address width; NREG = 2^RA registers of DW bits (RA ≤ DW)
- IW, 4+DW (fixed relation, 12 at defaults), instruction width: [IW-1:DW] opcode, [DW-1:0] operand
- clk  input  1  clock, all state on rising edge
- Rst  input  1  reset: one clock; reset is asynchronous and active-high
- instr_in  input  IW  instruction word
- instr_valid  input  1  instr_in is valid
- instr_ready  output  1  core can accept an instruction this cycle
- data_out  output  DW  last value written by OUT
- out_valid  output  1  one-cycle strobe when data_out is updated
- flag_c  output  1  carry/borrow flag
- flag_z  output  1  zero flag
- halted  output  1  core has executed HLT

## Operation
- Opcodes (imm = operand, r = reg[operand[RA-1:0]]):
  - 0 NOP
  - 1 LDI acc=imm
  - 2 ADDI acc+=imm
  - 3 SUBI acc-=imm
  - 4 ANDI
  - 5 ORI
  - 6 XORI
  - 7 ST r=acc
  - 8 LD acc=r
  - 9 ADD acc+=r
  - A SUB acc-=r
  - B SHL acc<<=1
  - C SHR acc>>=1
  - D OUT data_out=acc
  - E HLT
  - F reserved, executes as NOP
- Arithmetic is DW-bit modulo.
  - ADD/ADDI: flag_c = carry out of bit DW-1.
  - SUB/SUBI: flag_c = 1 when acc < operand (unsigned borrow).
  - SHL: flag_c = old acc[DW-1].
  - SHR: flag_c = old acc[0], logical shift with 0 shifted in.
- flag_z = (new acc == 0) after ops 1–6 and 8–C. Logic ops (4–6) and LDI/LD clear flag_c.
- ST, OUT, NOP, HLT and F leave acc and flags unchanged.
- FSM states:
  - FETCH: instr_ready=1. Transfer on instr_valid & instr_ready; latch instr_in; go to EXEC.
  - EXEC: instr_ready=0. Commit acc, flags, register, data_out and out_valid at the closing edge. Next state is FETCH, or HALT for opcode E.
  - HALT: instr_ready=0, halted=1. Stays in HALT until Rst.
- instr_valid without ready is ignored; the source must hold the word. The core does not buffer more than one instruction.

## Timing
- Reset values: state=FETCH, acc=0, all registers=0, flag_c=0, flag_z=1, data_out=0, out_valid=0, halted=0, instr_ready=1 (combinational from state).
- Throughput: one instruction per 2 cycles at most.
- Latency: instruction accepted at edge N; its results are visible after edge N+1.
- out_valid is high for exactly the cycle following the EXEC of an OUT. data_out holds its value until the next OUT.
- ST then LD of the same register in back-to-back instructions returns the stored value; no hazard exists because the FSM is non-pipelined.
- Rst asserted mid-EXEC: the instruction is discarded with no partial commit, and all state is at reset values immediately (asynchronous).
- halted asserts the cycle after the HLT EXEC edge. instr_valid in HALT is ignored.

## Structure
- Package acc_cpu_pkg holds:
  - opcode localparams OP_NOP..OP_RSV (4-bit)
  - state encoding FETCH/EXEC/HALT
- Sub-module acc_cpu_alu (combinational, parametrised DW):
  - inputs opcode, acc, operand (imm or r)
  - outputs result, carry, writes_acc
- The top module owns the FSM, register file, flags and output register.

## Test plan
- Reset → instr_ready=1, data_out=0x00, flag_z=1, flag_c=0, halted=0. Rst pulse mid-EXEC of LDI 0x55 → acc stays 0x00.
- LDI 0xFE (0x1FE), ADDI 0x03 (0x203), OUT (0xD00) → data_out=0x01, flag_c=1, flag_z=0, out_valid high exactly 1 cycle, 2 cycles after OUT accept.
- LDI 0x05, ST r2 (0x702), LDI 0x00 (flag_z=1), LD r2 (0x802), SUB r2 (0xA02) → acc=0x00, flag_z=1, flag_c=0. Then SUBI 0x01 → acc=0xFF, flag_c=1.
- LDI 0x81, SHL → acc=0x02, flag_c=1. SHR → acc=0x01, flag_c=0. XORI 0x01 → acc=0x00, flag_z=1.
- instr_valid held high continuously → instr_ready toggles 1/0, exactly one accept per 2 cycles. Word changed while ready=0 → not executed.
- HLT (0xE00) then LDI 0x33, OUT → halted=1, instr_ready=0, data_out unchanged. DW=16, RA=3 build repeats the ADDI wrap test with 0xFFFF+1 → acc=0x0000, flag_c=1.
